// File: rtl/ring_output_arbiter.sv
// ---------------------------------------------------------------------------
// ring_output_arbiter
//
// Output-port controller for one direction (CW or CCW) of a cardinal ring
// router. It shares the outgoing ring link between pass-through (forward)
// traffic and local NIC injection.
//
// The output buffer has two slots, one per virtual channel (even = VC 0,
// odd = VC 1). A polarity bit toggles every cycle. In a cycle with polarity p:
//   - the link side presents slot[p] and may drain it;
//   - the arbiter side may only fill slot[~p].
// The two sides therefore never touch the same slot in the same cycle.
// A packet accepted at polarity p appears on the link in the next cycle.
//
// Forwarded packets have their hop field logically shifted right by one
// (toward higher bit index in the [0:DATA_W-1] ordering) when stored.
// Injected packets are stored unmodified.
//
// Build option:
//   FWD_PRIORITY_EN  defined   -> forward traffic always wins a contended grant.
//                               No round-robin pointer is built.
//                    undefined -> round-robin between forward and inject.
//                               Forward is preferred after reset.
//
// Ports:
//   CLK        in   1       clock, rising edge
//   RESET      in   1       synchronous, active-high; drops buffered packets
//   polarity   out  1       current polarity, toggles every non-reset cycle
//   fwd_valid  in   1       forward packet offered
//   fwd_data   in   DATA_W  forward packet, bit order [0:DATA_W-1]
//   fwd_ready  out  1       forward packet accepted this cycle
//   inj_valid  in   1       local packet offered by the NIC
//   inj_data   in   DATA_W  local packet
//   inj_ready  out  1       local packet accepted this cycle
//   out_send   out  1       link data valid
//   out_ready  in   1       downstream can accept
//   out_data   out  DATA_W  link data (0 when the presented slot is empty)
// ---------------------------------------------------------------------------
module ring_output_arbiter #(
   parameter int DATA_W  = 64,
   parameter int VC_BIT  = 0,
   parameter int HOP_MSB = 8,
   parameter int HOP_LSB = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   output logic              polarity,
   input  logic              fwd_valid,
   input  logic [0:DATA_W-1] fwd_data,
   output logic              fwd_ready,
   input  logic              inj_valid,
   input  logic [0:DATA_W-1] inj_data,
   output logic              inj_ready,
   output logic              out_send,
   input  logic              out_ready,
   output logic [0:DATA_W-1] out_data
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic              polarity_reg;
   logic [1:0]        slot_full_reg;
   logic [0:DATA_W-1] slot_data_reg [2];

   // ------------------------------------------------------------------------
   // Slot roles for this cycle
   // ------------------------------------------------------------------------
   logic rd_slot;     // slot presented on the link
   logic wr_slot;     // slot the arbiter may fill (also the VC it accepts)

   assign rd_slot = polarity_reg;
   assign wr_slot = ~polarity_reg;

   // ------------------------------------------------------------------------
   // Hop-field rewrite for forwarded packets.
   // With the [0:DATA_W-1] ordering a logical right shift moves each bit to
   // the next higher index, and a zero enters at HOP_MSB.
   // ------------------------------------------------------------------------
   logic [0:DATA_W-1] fwd_shifted;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_hop
         if (gi == HOP_MSB) begin : g_fill
            assign fwd_shifted[gi] = 1'b0;
         end else if (gi > HOP_MSB && gi <= HOP_LSB) begin : g_shift
            assign fwd_shifted[gi] = fwd_data[gi-1];
         end else begin : g_pass
            assign fwd_shifted[gi] = fwd_data[gi];
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Eligibility. A requester may only compete for the slot being filled this
   // cycle. Its VC must match that slot, and the slot must be empty.
   // Requests are masked during reset so no ready escapes while RESET is high.
   // ------------------------------------------------------------------------
   logic fwd_elig;
   logic inj_elig;

   assign fwd_elig = !RESET && fwd_valid &&
                     (fwd_data[VC_BIT] == wr_slot) && !slot_full_reg[wr_slot];
   assign inj_elig = !RESET && inj_valid &&
                     (inj_data[VC_BIT] == wr_slot) && !slot_full_reg[wr_slot];

   // ------------------------------------------------------------------------
   // Grant
   // ------------------------------------------------------------------------
   logic grant_fwd;
   logic grant_inj;

`ifdef FWD_PRIORITY_EN
   // Forward traffic never waits for local traffic.
   assign grant_fwd = fwd_elig;
   assign grant_inj = inj_elig && !fwd_elig;
`else
   // rr_ptr_reg: 0 prefers forward, 1 prefers inject. After any grant it
   // points at the loser. Each requester therefore waits at most one
   // contended cycle.
   logic rr_ptr_reg;

   assign grant_fwd = fwd_elig && (!inj_elig || !rr_ptr_reg);
   assign grant_inj = inj_elig && (!fwd_elig ||  rr_ptr_reg);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rr_ptr_reg <= 1'b0;
      end else if (grant_fwd) begin
         rr_ptr_reg <= 1'b1;
      end else if (grant_inj) begin
         rr_ptr_reg <= 1'b0;
      end
   end
`endif

   logic              grant_any;
   logic [0:DATA_W-1] wr_data;

   assign grant_any = grant_fwd || grant_inj;
   assign wr_data   = grant_fwd ? fwd_shifted : inj_data;

   // ------------------------------------------------------------------------
   // Link side
   // ------------------------------------------------------------------------
   logic deq;

   assign deq = slot_full_reg[rd_slot] && out_ready;

   // ------------------------------------------------------------------------
   // Sequential update: polarity plus the two slots. Each slot is either the
   // read slot or the write slot in a given cycle, never both.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         polarity_reg  <= 1'b0;
         slot_full_reg <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            slot_data_reg[i] <= '0;
         end
      end else begin
         polarity_reg <= ~polarity_reg;
         for (int i = 0; i < 2; i++) begin
            if (rd_slot == 1'(i)) begin
               if (deq) begin
                  slot_full_reg[i] <= 1'b0;
               end
            end else if (grant_any) begin
               slot_full_reg[i] <= 1'b1;
               slot_data_reg[i] <= wr_data;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign polarity  = polarity_reg;
   assign out_send  = !RESET && slot_full_reg[rd_slot];
   assign out_data  = out_send ? slot_data_reg[rd_slot] : '0;
   assign fwd_ready = grant_fwd;
   assign inj_ready = grant_inj;

endmodule

// File: tb/tb_ring_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_output_arbiter
//
// Directed self-checking bench for ring_output_arbiter.
// Stimulus is driven 2 time units after each rising edge. Outputs are
// sampled 1 time unit later, well away from the next rising edge.
// ---------------------------------------------------------------------------
module tb_ring_output_arbiter;

   logic        CLK;
   logic        RESET;
   logic        polarity;
   logic        fwd_valid;
   logic [0:63] fwd_data;
   logic        fwd_ready;
   logic        inj_valid;
   logic [0:63] inj_data;
   logic        inj_ready;
   logic        out_send;
   logic        out_ready;
   logic [0:63] out_data;

   int test_cnt = 0;
   int fail_cnt = 0;

`ifdef FWD_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   ring_output_arbiter #(
      .DATA_W  (64),
      .VC_BIT  (0),
      .HOP_MSB (8),
      .HOP_LSB (15)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .polarity  (polarity),
      .fwd_valid (fwd_valid),
      .fwd_data  (fwd_data),
      .fwd_ready (fwd_ready),
      .inj_valid (inj_valid),
      .inj_data  (inj_data),
      .inj_ready (inj_ready),
      .out_send  (out_send),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Watchdog: the sequence is short. If it is exceeded, report and stop.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      test_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   // Build a packet: VC in bit 0, hop field in bits [8:15], tag byte in bits [56:63].
   function automatic logic [0:63] mk(input logic vc, input logic [7:0] hop, input logic [7:0] tag);
      logic [0:63] p;
      p        = '0;
      p[0]     = vc;
      p[8:15]  = hop;
      p[56:63] = tag;
      return p;
   endfunction

   logic [0:63] pkt;
   logic [0:63] exp_pkt;
   logic        exp_fwd;

   initial begin
      // ---------------- 1: reset held with valids high ----------------
      RESET     = 1'b1;
      fwd_valid = 1'b1;
      inj_valid = 1'b1;
      fwd_data  = mk(1'b1, 8'h04, 8'h01);
      inj_data  = mk(1'b1, 8'h00, 8'h02);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         check("rst_out_send", 64'(out_send), 64'd0);
         check("rst_fwd_ready", 64'(fwd_ready), 64'd0);
         check("rst_inj_ready", 64'(inj_ready), 64'd0);
         check("rst_polarity", 64'(polarity), 64'd0);
      end
      check("rst_out_data", 64'(out_data), 64'd0);
      RESET     = 1'b0;
      fwd_valid = 1'b0;
      inj_valid = 1'b0;
      #1;
      check("pol_seq0", 64'(polarity), 64'd0);
      tick(); #1;
      check("pol_seq1", 64'(polarity), 64'd1);
      tick(); #1;
      check("pol_seq2", 64'(polarity), 64'd0);

      // ---------------- 2: single inject packet, VC=1 at p=0 ----------------
      pkt       = 64'h8000_0000_0000_00AA;
      inj_valid = 1'b1;
      inj_data  = pkt;
      #1;
      check("t2_inj_ready", 64'(inj_ready), 64'd1);
      check("t2_fwd_ready", 64'(fwd_ready), 64'd0);
      check("t2_send_before", 64'(out_send), 64'd0);
      tick();
      inj_valid = 1'b0;
      #1;
      check("t2_out_send", 64'(out_send), 64'd1);
      check("t2_out_data", 64'(out_data), 64'(pkt));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick(); #1;                                  // p=1 again: slot 1 must be empty
      check("t2_drained", 64'(out_send), 64'd0);

      // ---------------- 3: forward hop shift, VC=0 at p=1 ----------------
      pkt          = mk(1'b0, 8'h04, 8'h33);
      pkt[16:23]   = 8'h5A;
      pkt[1:7]     = 7'h55;
      exp_pkt      = mk(1'b0, 8'h02, 8'h33);
      exp_pkt[16:23] = 8'h5A;
      exp_pkt[1:7]   = 7'h55;
      fwd_valid = 1'b1;
      fwd_data  = pkt;
      out_ready = 1'b1;
      #1;
      check("t3_pol", 64'(polarity), 64'd1);
      check("t3_fwd_ready", 64'(fwd_ready), 64'd1);
      check("t3_inj_ready", 64'(inj_ready), 64'd0);
      tick();
      fwd_valid = 1'b0;
      #1;
      check("t3_out_send", 64'(out_send), 64'd1);
      check("t3_out_data", 64'(out_data), 64'(exp_pkt));
      tick();                                      // p=1, slot 0 drained

      // ---------------- 4: contention on VC=1 ----------------
      // The last grant was forward (test 3), so round-robin prefers inject first.
      tick();                                      // p=0
      fwd_valid = 1'b1;
      fwd_data  = mk(1'b1, 8'h10, 8'h44);
      inj_valid = 1'b1;
      inj_data  = mk(1'b1, 8'h10, 8'h55);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_fwd = PRIO ? 1'b1 : (k % 2 == 1);
         #1;
         check($sformatf("t4_fwd_ready_%0d", k), 64'(fwd_ready), 64'(exp_fwd));
         check($sformatf("t4_inj_ready_%0d", k), 64'(inj_ready), 64'(!exp_fwd));
         tick(); #1;                               // p=1: odd VC not eligible
         check($sformatf("t4_idle_fwd_%0d", k), 64'(fwd_ready), 64'd0);
         check($sformatf("t4_idle_inj_%0d", k), 64'(inj_ready), 64'd0);
         exp_pkt = exp_fwd ? mk(1'b1, 8'h08, 8'h44) : mk(1'b1, 8'h10, 8'h55);
         check($sformatf("t4_out_data_%0d", k), 64'(out_data), 64'(exp_pkt));
         tick();
      end
      fwd_valid = 1'b0;
      inj_valid = 1'b0;

      // ---------------- 5: back-pressure on VC=0 ----------------
      out_ready = 1'b0;
      tick();                                      // p=1
      fwd_valid = 1'b1;
      fwd_data  = mk(1'b0, 8'h00, 8'hA1);
      #1;
      check("t5_a_accept", 64'(fwd_ready), 64'd1);
      tick();                                      // p=0
      fwd_data  = mk(1'b0, 8'h00, 8'hB1);
      inj_valid = 1'b1;
      inj_data  = mk(1'b1, 8'h00, 8'hD1);
      #1;
      check("t5_b_wrongvc", 64'(fwd_ready), 64'd0);
      check("t5_odd_accept", 64'(inj_ready), 64'd1);
      tick();                                      // p=1
      inj_valid = 1'b0;
      #1;
      check("t5_b_full", 64'(fwd_ready), 64'd0);
      check("t5_odd_out", 64'(out_data), 64'(mk(1'b1, 8'h00, 8'hD1)));
      tick(); #1;                                  // p=0
      check("t5_a_held", 64'(out_data), 64'(mk(1'b0, 8'h00, 8'hA1)));
      tick(); #1;                                  // p=1
      check("t5_b_still_full", 64'(fwd_ready), 64'd0);
      out_ready = 1'b1;
      tick(); #1;                                  // p=0, A drains at next edge
      check("t5_a_out", 64'(out_data), 64'(mk(1'b0, 8'h00, 8'hA1)));
      tick(); #1;                                  // p=1
      check("t5_b_accept", 64'(fwd_ready), 64'd1);
      check("t5_odd_gone", 64'(out_send), 64'd0);
      tick();                                      // p=0
      fwd_data = mk(1'b0, 8'h00, 8'hC1);
      #1;
      check("t5_b_out", 64'(out_data), 64'(mk(1'b0, 8'h00, 8'hB1)));
      tick(); #1;                                  // p=1
      check("t5_c_accept", 64'(fwd_ready), 64'd1);
      tick();                                      // p=0
      fwd_valid = 1'b0;
      #1;
      check("t5_c_out", 64'(out_data), 64'(mk(1'b0, 8'h00, 8'hC1)));
      tick();                                      // p=1

      // ---------------- 6: reset with both slots full ----------------
      out_ready = 1'b0;
      fwd_valid = 1'b1;
      fwd_data  = mk(1'b0, 8'h00, 8'hE1);
      #1;
      check("t6_fill_even", 64'(fwd_ready), 64'd1);
      tick();                                      // p=0
      fwd_valid = 1'b0;
      inj_valid = 1'b1;
      inj_data  = mk(1'b1, 8'h00, 8'hE2);
      #1;
      check("t6_fill_odd", 64'(inj_ready), 64'd1);
      check("t6_even_full", 64'(out_send), 64'd1);
      tick();                                      // p=1
      inj_valid = 1'b0;
      #1;
      check("t6_odd_full", 64'(out_send), 64'd1);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      #1;
      check("t6_pol_reset", 64'(polarity), 64'd0);
      check("t6_even_empty", 64'(out_send), 64'd0);
      tick(); #1;                                  // p=1
      check("t6_odd_empty", 64'(out_send), 64'd0);
      tick();                                      // p=0
      fwd_valid = 1'b1;
      fwd_data  = mk(1'b1, 8'h00, 8'hF1);
      inj_valid = 1'b1;
      inj_data  = mk(1'b1, 8'h00, 8'hF2);
      #1;
      check("t6_first_fwd", 64'(fwd_ready), 64'd1);
      check("t6_first_inj", 64'(inj_ready), 64'd0);
      tick();
      fwd_valid = 1'b0;
      inj_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
